// File: rtl/bpm_pkg.sv
// ============================================================================
// Module  : bpm_pkg
// Brief   : Shared framing constants, FSM encoding and checksum helper for
//           the BPM UART reporter and its RX-side checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bpm_pkg;

    localparam logic [7:0]  c_HDR_DEFAULT = 8'hAA;
    localparam int unsigned c_FRAME_LEN   = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_NEXT      = 3'd5
    } state_t;

    // Two's complement of the byte sum, so a whole frame sums to zero.
    function automatic logic [7:0] frame_chk(
        input logic [7:0] i_b0,
        input logic [7:0] i_b1,
        input logic [7:0] i_b2
    );
        logic [7:0] w_sum;
        w_sum = i_b0 + i_b1 + i_b2;
        return ~w_sum + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bpm_chk_calc.sv
// ============================================================================
// Module  : bpm_chk_calc
// Brief   : Combinational 3-byte frame checksum (shared with the RX checker).
// Revision: 1.0
// ============================================================================
`default_nettype none

module bpm_chk_calc
    import bpm_pkg::*;
(
    input  logic [7:0] i_hdr,
    input  logic [7:0] i_bpm,
    input  logic [7:0] i_sts,
    output logic [7:0] o_chk
);

    assign o_chk = frame_chk(i_hdr, i_bpm, i_sts);

endmodule

`default_nettype wire

// File: rtl/bpm_uart_reporter.sv
// ============================================================================
// Module  : bpm_uart_reporter
// Brief   : Frames BPM results as HDR,BPM,STATUS,CHK and sequences the bytes
//           onto a UART byte transmitter, with idle heartbeat resend.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bpm_uart_reporter
    import bpm_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE      = c_HDR_DEFAULT,
    parameter int unsigned HEARTBEAT_CYC = 1_000_000,
    parameter int unsigned ACK_TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_bpm_valid,
    input  logic [7:0]  i_bpm_value,
    input  logic [7:0]  i_bpm_status,
    input  logic        i_uart_busy,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_frame_active,
    output logic [15:0] o_frames_sent,
    output logic        o_overrun,
    output logic        o_ack_err
);

    localparam int unsigned        c_ACK_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [c_ACK_W-1:0] c_ACK_LAST = c_ACK_W'(ACK_TIMEOUT - 1);
    localparam logic               c_HB_EN    = (HEARTBEAT_CYC != 0);
    localparam logic [31:0]        c_HB_LAST  = (HEARTBEAT_CYC == 0) ? 32'd0 : 32'(HEARTBEAT_CYC - 1);
    localparam logic [1:0]         c_LAST_IDX = 2'(c_FRAME_LEN - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_pend_flag;
    logic [7:0]         r_pend_val;
    logic [7:0]         r_pend_sts;
    logic [7:0]         r_frm_val;
    logic [7:0]         r_frm_sts;
    logic [7:0]         r_chk;
    logic               r_ever_loaded;
    logic [1:0]         r_byte_idx;
    logic [c_ACK_W-1:0] r_ack_cnt;
    logic [31:0]        r_hb_cnt;

    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic               r_frame_active;
    logic [15:0]        r_frames_sent;
    logic               r_overrun;
    logic               r_ack_err;

    logic               w_launch_new;
    logic               w_launch_hb;
    logic               w_launch;
    logic               w_tx_fire;
    logic               w_ack_tmo;
    logic               w_frame_done;
    logic               w_hb_due;
    logic [7:0]         w_chk;
    logic [7:0]         w_cur_byte;

    bpm_chk_calc u_chk (
        .i_hdr (HDR_BYTE),
        .i_bpm (r_frm_val),
        .i_sts (r_frm_sts),
        .o_chk (w_chk)
    );

    assign w_hb_due = c_HB_EN && (r_hb_cnt == c_HB_LAST);
    assign w_launch = w_launch_new | w_launch_hb;

    always_comb begin
        w_cur_byte = HDR_BYTE;
        case (r_byte_idx)
            2'd1:    w_cur_byte = r_frm_val;
            2'd2:    w_cur_byte = r_frm_sts;
            2'd3:    w_cur_byte = r_chk;
            default: w_cur_byte = HDR_BYTE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_launch_new = 1'b0;
        w_launch_hb  = 1'b0;
        w_tx_fire    = 1'b0;
        w_ack_tmo    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Fresh data always takes priority over a heartbeat resend.
                if (r_pend_flag) begin
                    w_launch_new = 1'b1;
                    w_state_nxt  = S_LOAD;
                end else if (w_hb_due && r_ever_loaded) begin
                    w_launch_hb = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_START;
            end
            S_START: begin
                if (!i_uart_busy) begin
                    w_tx_fire   = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_uart_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_ack_cnt == c_ACK_LAST) begin
                    w_ack_tmo   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!i_uart_busy) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (r_byte_idx == c_LAST_IDX) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A strobe in the launch cycle refills the buffer after the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_flag   <= 1'b0;
            r_pend_val    <= 8'd0;
            r_pend_sts    <= 8'd0;
            r_overrun     <= 1'b0;
            r_frm_val     <= 8'd0;
            r_frm_sts     <= 8'd0;
            r_ever_loaded <= 1'b0;
        end else begin
            if (i_bpm_valid) begin
                r_pend_val  <= i_bpm_value;
                r_pend_sts  <= i_bpm_status;
                r_pend_flag <= 1'b1;
                if (r_pend_flag && !w_launch_new) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_launch_new) begin
                r_pend_flag <= 1'b0;
            end
            if (w_launch_new) begin
                r_frm_val     <= r_pend_val;
                r_frm_sts     <= r_pend_sts;
                r_ever_loaded <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk      <= 8'd0;
            r_byte_idx <= 2'd0;
            r_ack_cnt  <= '0;
            r_hb_cnt   <= 32'd0;
        end else begin
            if (r_state == S_LOAD) begin
                r_chk      <= w_chk;
                r_byte_idx <= 2'd0;
            end else if ((r_state == S_NEXT) && !w_frame_done) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (w_tx_fire) begin
                r_ack_cnt <= '0;
            end else if (r_state == S_WAIT_ACK) begin
                r_ack_cnt <= r_ack_cnt + 1'b1;
            end
            // Holds at the due value until a frame has ever been loaded.
            if (w_launch || w_frame_done) begin
                r_hb_cnt <= 32'd0;
            end else if ((r_state == S_IDLE) && !r_pend_flag && c_HB_EN && !w_hb_due) begin
                r_hb_cnt <= r_hb_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_start     <= 1'b0;
            r_tx_data      <= 8'd0;
            r_frame_active <= 1'b0;
            r_frames_sent  <= 16'd0;
            r_ack_err      <= 1'b0;
        end else begin
            r_tx_start <= w_tx_fire;
            if (w_tx_fire) begin
                r_tx_data <= w_cur_byte;
            end
            if (w_launch) begin
                r_frame_active <= 1'b1;
            end else if (w_frame_done || w_ack_tmo) begin
                r_frame_active <= 1'b0;
            end
            if (w_frame_done) begin
                r_frames_sent <= r_frames_sent + 16'd1;
            end
            if (w_ack_tmo) begin
                r_ack_err <= 1'b1;
            end
        end
    end

    assign o_tx_start     = r_tx_start;
    assign o_tx_data      = r_tx_data;
    assign o_frame_active = r_frame_active;
    assign o_frames_sent  = r_frames_sent;
    assign o_overrun      = r_overrun;
    assign o_ack_err      = r_ack_err;

endmodule

`default_nettype wire

// File: tb/tb_bpm_uart_reporter.sv
// ============================================================================
// Module  : tb_bpm_uart_reporter
// Brief   : Self-checking bench for bpm_uart_reporter with a behavioural UART.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bpm_uart_reporter;

    localparam int c_HB  = 2000;
    localparam int c_ACK = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_bpm_valid = 1'b0;
    logic [7:0]  i_bpm_value = 8'd0;
    logic [7:0]  i_bpm_status = 8'd0;
    logic        uart_busy;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_frame_active;
    logic [15:0] o_frames_sent;
    logic        o_overrun;
    logic        o_ack_err;

    int n_checks = 0;
    int n_errors = 0;

    bpm_uart_reporter #(
        .HDR_BYTE      (8'hAA),
        .HEARTBEAT_CYC (c_HB),
        .ACK_TIMEOUT   (c_ACK)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_bpm_valid    (i_bpm_valid),
        .i_bpm_value    (i_bpm_value),
        .i_bpm_status   (i_bpm_status),
        .i_uart_busy    (uart_busy),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .o_frame_active (o_frame_active),
        .o_frames_sent  (o_frames_sent),
        .o_overrun      (o_overrun),
        .o_ack_err      (o_ack_err)
    );

    always #500 clk = ~clk;

    // Behavioural UART: accepts a byte on tx_start, then stays busy a while.
    logic       uart_en = 1'b1;
    int         busy_cnt;
    int         start_while_busy = 0;
    logic [7:0] rx_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_busy <= 1'b0;
            busy_cnt  <= 0;
            rx_q.delete();
        end else begin
            if (o_tx_start && uart_busy) start_while_busy <= start_while_busy + 1;
            if (busy_cnt != 0) begin
                busy_cnt  <= busy_cnt - 1;
                uart_busy <= (busy_cnt != 1);
            end else if (o_tx_start && uart_en) begin
                uart_busy <= 1'b1;
                busy_cnt  <= int'($urandom_range(30, 8));
                rx_q.push_back(o_tx_data);
            end
        end
    end

    initial begin
        #(64'd100_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int rd_ptr = 0;
    int exp_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_chk(input int v, input int s);
        int sum;
        sum = (170 + v + s) % 256;
        return 8'((256 - sum) % 256);
    endfunction

    task automatic strobe(input logic [7:0] v, input logic [7:0] s);
        i_bpm_valid  = 1'b1;
        i_bpm_value  = v;
        i_bpm_status = s;
        @(negedge clk);
        i_bpm_valid  = 1'b0;
    endtask

    task automatic wait_idle_bytes(input int n, input string name);
        int cyc = 0;
        while (!((rx_q.size() >= rd_ptr + n) && !o_frame_active) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_done"}, 32'(cyc < 4000), 32'd1);
    endtask

    task automatic wait_active(input string name);
        int cyc = 0;
        while (!o_frame_active && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_launch"}, 32'(o_frame_active), 32'd1);
    endtask

    task automatic check_frame(input string name, input logic [7:0] v, input logic [7:0] s,
                               input logic [7:0] chk);
        logic [7:0] b[4];
        for (int i = 0; i < 4; i++) begin
            b[i] = (rd_ptr < rx_q.size()) ? rx_q[rd_ptr] : 8'h00;
            rd_ptr++;
        end
        check({name, "_hdr"}, 32'(b[0]), 32'h0AA);
        check({name, "_bpm"}, 32'(b[1]), 32'(v));
        check({name, "_sts"}, 32'(b[2]), 32'(s));
        check({name, "_chk"}, 32'(b[3]), 32'(chk));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tx_start"}, 32'(o_tx_start), 32'd0);
        check({name, "_tx_data"}, 32'(o_tx_data), 32'd0);
        check({name, "_frame_active"}, 32'(o_frame_active), 32'd0);
        check({name, "_frames_sent"}, 32'(o_frames_sent), 32'd0);
        check({name, "_overrun"}, 32'(o_overrun), 32'd0);
        check({name, "_ack_err"}, 32'(o_ack_err), 32'd0);
    endtask

    typedef struct {
        logic [7:0] v;
        logic [7:0] s;
        logic [7:0] chk;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] lv, ls, nv, ns;
        int         k, cyc, pulses, sent_before;
        logic       exp_ovr;

        tbl[0] = '{8'h78, 8'h00, 8'hDE};
        tbl[1] = '{8'h55, 8'h01, 8'h00};
        tbl[2] = '{8'h00, 8'h00, 8'h56};
        tbl[3] = '{8'hFF, 8'hFF, 8'h58};
        tbl[4] = '{8'h01, 8'h02, 8'h53};
        tbl[5] = '{8'h10, 8'h20, 8'h26};

        // Reset values
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            strobe(tbl[i].v, tbl[i].s);
            wait_idle_bytes(4, $sformatf("tbl%0d", i));
            check_frame($sformatf("tbl%0d", i), tbl[i].v, tbl[i].s, tbl[i].chk);
            exp_frames++;
            check($sformatf("tbl%0d_frames_sent", i), 32'(o_frames_sent), 32'(exp_frames));
            repeat (3) @(negedge clk);
        end
        check("tbl_overrun", 32'(o_overrun), 32'd0);
        check("tbl_ack_err", 32'(o_ack_err), 32'd0);

        // Random: lead frame, then 1..3 strobes mid-frame; newest must win
        exp_ovr = 1'b0;
        for (int it = 0; it < 6; it++) begin
            lv = 8'($urandom);
            ls = 8'($urandom);
            strobe(lv, ls);
            wait_active($sformatf("rnd%0d", it));
            k = (it == 0) ? 1 : int'($urandom_range(3, 1));
            nv = 8'd0;
            ns = 8'd0;
            for (int j = 0; j < k; j++) begin
                repeat (int'($urandom_range(4, 1))) @(negedge clk);
                nv = 8'($urandom);
                ns = 8'($urandom);
                strobe(nv, ns);
            end
            if (k >= 2) exp_ovr = 1'b1;
            wait_idle_bytes(8, $sformatf("rnd%0d", it));
            check_frame($sformatf("rnd%0d_a", it), lv, ls, ref_chk(int'(lv), int'(ls)));
            check_frame($sformatf("rnd%0d_b", it), nv, ns, ref_chk(int'(nv), int'(ns)));
            exp_frames += 2;
            check($sformatf("rnd%0d_frames_sent", it), 32'(o_frames_sent), 32'(exp_frames));
            check($sformatf("rnd%0d_overrun", it), 32'(o_overrun), 32'(exp_ovr));
            repeat (3) @(negedge clk);
        end

        // Directed overrun: three strobes during one frame, only two frames
        strobe(8'h78, 8'h00);
        wait_active("ovr");
        repeat (2) @(negedge clk);
        strobe(8'h50, 8'h00);
        @(negedge clk);
        strobe(8'h60, 8'h00);
        @(negedge clk);
        strobe(8'h70, 8'h00);
        wait_idle_bytes(8, "ovr");
        check_frame("ovr_a", 8'h78, 8'h00, 8'hDE);
        check_frame("ovr_b", 8'h70, 8'h00, 8'hE6);
        exp_frames += 2;
        check("ovr_frames_sent", 32'(o_frames_sent), 32'(exp_frames));
        check("ovr_overrun", 32'(o_overrun), 32'd1);
        repeat (200) @(negedge clk);
        check("ovr_no_third_frame", 32'(rx_q.size()), 32'(rd_ptr));

        // Heartbeat: identical frame exactly c_HB idle cycles after completion
        strobe(8'h78, 8'h00);
        wait_idle_bytes(4, "hb_src");
        check_frame("hb_src", 8'h78, 8'h00, 8'hDE);
        exp_frames++;
        cyc = 0;
        while (!o_frame_active && cyc < c_HB + 500) begin
            @(negedge clk);
            cyc++;
        end
        check("hb_gap", 32'(cyc), 32'(c_HB));
        wait_idle_bytes(4, "hb");
        check_frame("hb", 8'h78, 8'h00, 8'hDE);
        exp_frames++;
        check("hb_frames_sent", 32'(o_frames_sent), 32'(exp_frames));

        // ACK timeout: UART never raises busy
        repeat (3) @(negedge clk);
        uart_en = 1'b0;
        strobe(8'h33, 8'h44);
        cyc = 0;
        while (!o_tx_start && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("ack_tx_start_seen", 32'(o_tx_start), 32'd1);
        cyc = 0;
        while (!o_ack_err && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("ack_latency", 32'(cyc), 32'(c_ACK));
        check("ack_err", 32'(o_ack_err), 32'd1);
        @(negedge clk);
        check("ack_frame_active", 32'(o_frame_active), 32'd0);
        check("ack_frames_sent", 32'(o_frames_sent), 32'(exp_frames));
        uart_en = 1'b1;
        repeat (20) @(negedge clk);
        check("ack_no_retry", 32'(rx_q.size()), 32'(rd_ptr));

        // Reset mid-frame during the BPM byte
        strobe(8'h9A, 8'h01);
        cyc = 0;
        while (rx_q.size() < rd_ptr + 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_bpm_byte", 32'(rx_q.size() >= rd_ptr + 2), 32'd1);
        #200;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(negedge clk);
        rd_ptr = 0;
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < c_HB + 300; c++) begin
            @(negedge clk);
            if (o_tx_start) pulses++;
        end
        check("rst_no_frame", 32'(pulses), 32'd0);
        check("rst_frame_active", 32'(o_frame_active), 32'd0);
        sent_before = int'(o_frames_sent);
        check("rst_frames_sent", 32'(sent_before), 32'd0);
        strobe(8'h64, 8'h02);
        wait_idle_bytes(4, "post_rst");
        check_frame("post_rst", 8'h64, 8'h02, ref_chk(8'h64, 8'h02));
        check("post_rst_frames_sent", 32'(o_frames_sent), 32'd1);

        check("start_while_busy", 32'(start_while_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
